// File: rtl/mealy_seq_transmitter.sv
// Serial frame source for the Mealy sequence detector: sync pattern, MSB-first payload, idle gap.
// Define MEALY_TX_PARITY_EN to append an even-parity bit after the payload (done moves onto it).
module mealy_seq_transmitter #(
    parameter int                  SYNC_LEN   = 4,
    parameter logic [SYNC_LEN-1:0] SYNC_PAT   = 4'b1011,
    parameter int                  DATA_W     = 8,
    parameter int                  GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              out,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX_SD = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
    localparam int CNT_MAX    = (CNT_MAX_SD > GAP_CYCLES) ? CNT_MAX_SD : GAP_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd4;

    // With no gap the frame drops straight back to IDLE and busy clears with it.
    localparam logic [2:0] S_AFTER    = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
    localparam logic       BUSY_AFTER = (GAP_CYCLES > 0) ? 1'b1 : 1'b0;

`ifdef MEALY_TX_PARITY_EN
    localparam logic [2:0] S_PARITY     = 3'd3;
    localparam logic       DONE_IN_DATA = 1'b0;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`else
    localparam logic       DONE_IN_DATA = 1'b1;
`endif

    logic [2:0]          r_state, w_state;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [DATA_W-1:0]   r_shift, w_shift;
    logic [SYNC_LEN-1:0] r_sync, w_sync;
    logic                r_out, w_out;
    logic                r_valid, w_valid;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
`ifdef MEALY_TX_PARITY_EN
    logic                r_par, w_par;
`endif

    // Outputs are registered: each branch computes what the next cycle shows.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_shift = r_shift;
        w_sync  = r_sync;
        w_out   = 1'b0;
        w_valid = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
`ifdef MEALY_TX_PARITY_EN
        w_par   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state = S_SYNC;
                    w_cnt   = '0;
                    w_shift = data_in;
                    w_sync  = SYNC_PAT << 1;
                    w_out   = SYNC_PAT[SYNC_LEN-1];
                    w_valid = 1'b1;
                    w_busy  = 1'b1;
`ifdef MEALY_TX_PARITY_EN
                    w_par   = even_parity(data_in);
`endif
                end
            end
            S_SYNC: begin
                w_valid = 1'b1;
                w_busy  = 1'b1;
                if (r_cnt != SYNC_LAST) begin
                    w_cnt  = r_cnt + CNT_ONE;
                    w_out  = r_sync[SYNC_LEN-1];
                    w_sync = r_sync << 1;
                end else begin
                    w_state = S_DATA;
                    w_cnt   = '0;
                    w_out   = r_shift[DATA_W-1];
                    w_shift = r_shift << 1;
                    w_done  = DONE_IN_DATA && (DATA_LAST == '0);
                end
            end
            S_DATA: begin
                if (r_cnt != DATA_LAST) begin
                    w_valid = 1'b1;
                    w_busy  = 1'b1;
                    w_cnt   = r_cnt + CNT_ONE;
                    w_out   = r_shift[DATA_W-1];
                    w_shift = r_shift << 1;
                    w_done  = DONE_IN_DATA && ((r_cnt + CNT_ONE) == DATA_LAST);
                end else begin
`ifdef MEALY_TX_PARITY_EN
                    w_state = S_PARITY;
                    w_valid = 1'b1;
                    w_busy  = 1'b1;
                    w_out   = r_par;
                    w_done  = 1'b1;
`else
                    w_state = S_AFTER;
                    w_cnt   = '0;
                    w_busy  = BUSY_AFTER;
`endif
                end
            end
`ifdef MEALY_TX_PARITY_EN
            S_PARITY: begin
                w_state = S_AFTER;
                w_cnt   = '0;
                w_busy  = BUSY_AFTER;
            end
`endif
            S_GAP: begin
                if (r_cnt != GAP_LAST) begin
                    w_cnt  = r_cnt + CNT_ONE;
                    w_busy = 1'b1;
                end else begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_sync  <= '0;
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef MEALY_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_shift <= w_shift;
            r_sync  <= w_sync;
            r_out   <= w_out;
            r_valid <= w_valid;
            r_busy  <= w_busy;
            r_done  <= w_done;
`ifdef MEALY_TX_PARITY_EN
            r_par   <= w_par;
`endif
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
